seq_detect_ctrl: RTL

Controller that sequences a programmable serial-pattern detector over a bounded window of a qualified bit stream. A requester configures a pattern, length, overlap mode and window size, then pulses start. The block consumes exactly the requested number of valid bits, counts pattern matches, and reports completion. It sits between a control master and the serial bit source, and generalises the team's fixed 1010 Moore detectors into a runtime-configured, framed resource.

---
 rtl/seq_det_pkg.sv | 9 +
 rtl/seq_match_core.sv | 38 +++
 rtl/seq_detect_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type, default sizes and pattern-length clamp for the sequence detector.
package seq_det_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W = 8;
    function automatic int clamp_len(int len, int max_len);
        return (len < 1) ? 1 : ((len > max_len) ? max_len : len);
    endfunction
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: history shift register, fill counter and masked pattern compare.
import seq_det_pkg::*;
module seq_match_core #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [LW-1:0]      len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               overlap,
    input  logic               clr,
    output logic               match
);
    logic [MAX_LEN-1:0] hist, hist_next, mask;
    logic [LW-1:0] fill, fill_next;
    // match looks at the history as it will be after this bit, so the strobe lines up with the accepted bit
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], bit_in};
        fill_next = (fill == LW'(MAX_LEN)) ? fill : fill + 1'b1;
        mask = ~({MAX_LEN{1'b1}} << len);
        match = shift_en && (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
            fill <= (match && !overlap) ? '0 : fill_next;
        end
    end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: framed, runtime-configured serial pattern detector over a window of valid bits.
import seq_det_pkg::*;
module seq_detect_ctrl #(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W = DEF_CNT_W,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_window,
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               busy,
    output logic               done,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic [CNT_W-1:0]   first_idx,
    output logic               found
);
    state_t state, state_next;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LW-1:0] len_q;
    logic overlap_q;
    logic [CNT_W-1:0] window_q, idx;
    logic launch, accept, last, match, busy_next, done_next;

    assign launch = (state == IDLE) && start;
    assign accept = (state == RUN) && bit_valid;
    assign last = (idx == window_q - 1'b1);

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk(clk),
        .reset(reset),
        .shift_en(accept),
        .bit_in(bit_in),
        .len(len_q),
        .pattern(pattern_q),
        .overlap(overlap_q),
        .clr(launch),
        .match(match)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = launch ? ((cfg_window == '0) ? DONE : RUN)
                   : (accept && last) ? DONE
                   : (state == DONE) ? IDLE
                   : state;
    end

    // outputs are registered from the next state so they track the FSM without an input-to-output path
    always_comb begin
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= '0;
            first_idx <= '0;
            found <= 1'b0;
            pattern_q <= '0;
            len_q <= '0;
            overlap_q <= 1'b0;
            window_q <= '0;
            idx <= '0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            match_pulse <= match;
            if (launch) begin
                pattern_q <= cfg_pattern;
                len_q <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
                overlap_q <= cfg_overlap;
                window_q <= cfg_window;
                idx <= '0;
                match_count <= '0;
                first_idx <= '0;
                found <= 1'b0;
            end else if (accept) begin
                idx <= idx + 1'b1;
                if (match) begin
                    match_count <= (&match_count) ? match_count : match_count + 1'b1;
                    if (!found) begin
                        first_idx <= idx;
                        found <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
